// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter that lets NUM_ACC accelerator control units share one
// data-memory port. Each grant runs as one transaction through the
// ARB -> ISSUE -> (WAIT) -> RESP states. Address and data are captured at grant
// time, so later changes by the requester do not affect a transaction in flight.
module acc_mem_arbiter #(
    parameter int NUM_ACC        = 4,
    parameter int ADDR_SIZE      = 16,
    parameter int RD_DATA_SIZE   = 512,
    parameter int WR_DATA_SIZE   = 32,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_ACC-1:0]              acc_read_en,
    input  logic [NUM_ACC*ADDR_SIZE-1:0]    acc_read_addr,
    input  logic [NUM_ACC-1:0]              acc_write_en,
    input  logic [NUM_ACC*ADDR_SIZE-1:0]    acc_write_addr,
    input  logic [NUM_ACC*WR_DATA_SIZE-1:0] acc_write_data,
    input  logic                            cpu_mem_busy,
    input  logic [RD_DATA_SIZE-1:0]         mem_rd_data,
    output logic [RD_DATA_SIZE-1:0]         acc_read_data,
    output logic [NUM_ACC-1:0]              acc_read_data_valid,
    output logic [NUM_ACC-1:0]              acc_write_done,
    output logic                            mem_rd_en,
    output logic                            mem_wr_en,
    output logic [ADDR_SIZE-1:0]            mem_addr,
    output logic [WR_DATA_SIZE-1:0]         mem_wr_data,
    output logic                            arb_busy
);

    localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam int LAT_W = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;

    typedef enum logic [1:0] {ARB, ISSUE, WAIT, RESP} state_t;

    state_t                    state_reg,   state_next;
    logic [IDX_W-1:0]          rr_ptr_reg,  rr_ptr_next;
    logic [IDX_W-1:0]          gnt_idx_reg, gnt_idx_next;
    logic                      gnt_read_reg, gnt_read_next;
    logic [ADDR_SIZE-1:0]      addr_reg,    addr_next;
    logic [WR_DATA_SIZE-1:0]   wr_data_reg, wr_data_next;
    logic [LAT_W-1:0]          lat_cnt_reg, lat_cnt_next;
    logic [RD_DATA_SIZE-1:0]   rd_data_reg, rd_data_next;

    logic [NUM_ACC-1:0]        pending;
    logic                      sel_found;
    logic [IDX_W-1:0]          sel_idx;

    // A requester is pending when it asks for either a read or a write;
    // completion pulses are decoded from the granted index during RESP.
    for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_per_acc
        assign pending[gi]             = acc_read_en[gi] | acc_write_en[gi];
        assign acc_read_data_valid[gi] = (state_reg == RESP) && gnt_read_reg
                                         && (gnt_idx_reg == IDX_W'(gi));
        assign acc_write_done[gi]      = (state_reg == RESP) && !gnt_read_reg
                                         && (gnt_idx_reg == IDX_W'(gi));
    end

    assign acc_read_data = rd_data_reg;
    assign arb_busy      = (state_reg != ARB);

    // Round-robin pick: first pending requester at or after rr_ptr, wrapping.
    always_comb begin
        logic [31:0]      cand;
        logic [IDX_W-1:0] cand_idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_ACC; k++) begin
            cand     = (32'(rr_ptr_reg) + 32'(k)) % 32'(NUM_ACC);
            cand_idx = IDX_W'(cand);
            if (!sel_found && pending[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // Next-state, transaction latching and memory strobes.
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        gnt_idx_next  = gnt_idx_reg;
        gnt_read_next = gnt_read_reg;
        addr_next     = addr_reg;
        wr_data_next  = wr_data_reg;
        lat_cnt_next  = lat_cnt_reg;
        rd_data_next  = rd_data_reg;
        mem_rd_en     = 1'b0;
        mem_wr_en     = 1'b0;
        mem_addr      = '0;
        mem_wr_data   = '0;
        case (state_reg)
            ARB: begin
                // CPU ownership only blocks new grants, never committed ones.
                if (!cpu_mem_busy && sel_found) begin
                    gnt_idx_next  = sel_idx;
                    // A read takes priority over a write from the same unit;
                    // the write stays pending for a later grant.
                    gnt_read_next = acc_read_en[sel_idx];
                    addr_next     = acc_read_en[sel_idx]
                                    ? acc_read_addr[sel_idx*ADDR_SIZE +: ADDR_SIZE]
                                    : acc_write_addr[sel_idx*ADDR_SIZE +: ADDR_SIZE];
                    wr_data_next  = acc_write_data[sel_idx*WR_DATA_SIZE +: WR_DATA_SIZE];
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr     = addr_reg;
                lat_cnt_next = '0;
                if (gnt_read_reg) begin
                    mem_rd_en  = 1'b1;
                    state_next = WAIT;
                end else begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = wr_data_reg;
                    state_next  = RESP;
                end
            end
            WAIT: begin
                if (lat_cnt_reg == LAT_W'(MEM_RD_LATENCY - 1)) begin
                    rd_data_next = mem_rd_data;
                    state_next   = RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 1'b1;
                end
            end
            RESP: begin
                rr_ptr_next = (gnt_idx_reg == IDX_W'(NUM_ACC - 1)) ? '0
                                                                   : gnt_idx_reg + 1'b1;
                state_next  = ARB;
            end
            default: state_next = ARB;
        endcase
    end

    // State registers; reset abandons any in-flight transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ARB;
            rr_ptr_reg   <= '0;
            gnt_idx_reg  <= '0;
            gnt_read_reg <= 1'b0;
            addr_reg     <= '0;
            wr_data_reg  <= '0;
            lat_cnt_reg  <= '0;
            rd_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            gnt_idx_reg  <= gnt_idx_next;
            gnt_read_reg <= gnt_read_next;
            addr_reg     <= addr_next;
            wr_data_reg  <= wr_data_next;
            lat_cnt_reg  <= lat_cnt_next;
            rd_data_reg  <= rd_data_next;
        end
    end

endmodule
